game_turn_controller: RTL
=========================

Name: game_turn_controller

Overview:
- Sequences the two-player code-guessing game: latches each player's secret, alternates guess turns, and issues one check request per guess to the shared guess checker.
- Collects the checker result and decides win/draw.
- Drives state and score information for the display mux.
- Sits between the debounced button / switch bank and the check_guess datapath, replacing the ad-hoc top-level state logic.

Parameters:
- DIGITS, 4, number of hex digits per code; win when right-place count equals DIGITS.
- MAX_GUESSES, 10, guesses allowed per player before a draw is declared.
- WIN_HOLD_CYCLES, 256, cycles a win/draw result is held before returning to IDLE.
- CHK_TIMEOUT, 16, cycles to wait for chk_valid before abandoning a check.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_pulse  in  1  debounced single-cycle button strobe
- sw_value  in  4*DIGITS  live switch code
- chk_result  in  8  {wrong_place[7:4], right_place[3:0]} from checker
- chk_valid  in  1  one-cycle result strobe from checker
- chk_start  out  1  one-cycle check request
- chk_answer  out  4*DIGITS  secret being checked against
- chk_guess  out  4*DIGITS  latched guess
- active_player  out  1  0=P1, 1=P2
- state_code  out  4  current FSM state encoding
- last_result  out  8  most recent checker result, held
- guess_cnt_p1  out  4  guesses used by P1
- guess_cnt_p2  out  4  guesses used by P2
- win_p1  out  1  high while in P1_WINS
- win_p2  out  1  high while in P2_WINS
- draw  out  1  high while in DRAW
- err  out  1  one-cycle error pulse (timeout or rejected secret)

Behaviour:
- Reset values:
  - All outputs 0.
  - Secrets, chk_guess and counters cleared.
  - State IDLE.
  - rst mid-game aborts immediately; no partial result is retained.
- State encodings, fixed:
  - IDLE=0, P1_SECRET=1, P2_SECRET=2, P1_TURN=3, P1_CHECK=4, P2_TURN=5, P2_CHECK=6, P1_WINS=7, P2_WINS=8, DRAW=9.
- IDLE:
  - btn_pulse -> P1_SECRET.
  - Counters and last_result cleared on this transition.
- P1_SECRET:
  - btn_pulse latches sw_value into secret_p1 -> P2_SECRET.
- P2_SECRET:
  - btn_pulse latches sw_value into secret_p2 -> P1_TURN.
- P1_TURN (active_player=0):
  - btn_pulse latches sw_value into chk_guess and sets chk_answer=secret_p2.
  - chk_start is asserted in the cycle after the latch; chk_guess and chk_answer are stable that cycle.
  - Then -> P1_CHECK.
- P1_CHECK:
  - btn_pulse ignored.
  - On chk_valid:
    - last_result<=chk_result and guess_cnt_p1 increments.
    - If chk_result[3:0]==DIGITS -> P1_WINS, else -> P2_TURN.
  - No chk_valid within CHK_TIMEOUT cycles of chk_start:
    - pulse err, no count increment, -> P1_TURN.
- P2_TURN / P2_CHECK:
  - Symmetric, with chk_answer=secret_p1 and guess_cnt_p2.
  - On non-winning chk_valid:
    - If guess_cnt_p2 (after increment) == MAX_GUESSES -> DRAW, else -> P1_TURN.
- chk_valid rules:
  - Outside a CHECK state, chk_valid is ignored.
  - chk_valid in the same cycle as timeout expiry counts as valid; the result wins over the timeout.
- P1_WINS / P2_WINS / DRAW:
  - Corresponding flag high.
  - Hold counter runs 0..WIN_HOLD_CYCLES-1, then -> IDLE.
  - btn_pulse ignored.
- Counters:
  - Guess counters saturate at MAX_GUESSES.
  - Hold and timeout counters reset on every state entry.
- Exactly one chk_start per accepted guess; never two outstanding requests.

Optional Feature:
- Macro UNIQUE_DIGITS_EN.
- Defined: in P1_SECRET/P2_SECRET, a code with any two equal nibbles is rejected. err pulses for one cycle, the state does not advance, and the secret is unchanged.
- Undefined: any code is accepted and no duplicate-check logic is built.

Decomposition:
- Shared package game_pkg holds:
  - the state encodings;
  - the result-field positions (right_place=[3:0], wrong_place=[7:4]);
  - the default DIGITS and MAX_GUESSES constants.
- One natural sub-module, cycle_timer: a loadable down-counter with an expiry flag, instanced for the check timeout and the win hold.

Test Plan:
- Basic win: rst; btn -> P1_SECRET; secret 16'h1234, btn; secret 16'h5678, btn; P1 guesses 16'h5678, btn.
  - Exactly one chk_start with chk_answer=16'h5678.
  - Checker returns 8'h04 -> P1_WINS, win_p1=1.
  - After 256 cycles -> IDLE.
- Miss then P2 win: P1 guess 16'h0000 returns 8'h10 -> P2_TURN, last_result=8'h10, guess_cnt_p1=1. P2 guesses 16'h1234, result 8'h04 -> P2_WINS.
- Draw: MAX_GUESSES=10, all results 8'h00 -> DRAW after the 10th P2 check; guess_cnt_p1=guess_cnt_p2=10.
- Timeout: in P1_CHECK withhold chk_valid for 16 cycles -> err pulse, return to P1_TURN, guess_cnt_p1 unchanged. A late chk_valid is ignored.
- Button ignored: btn_pulse during P1_CHECK and P1_WINS causes no state change and no extra chk_start.
- Reset and secret rules: rst asserted in P2_CHECK -> next cycle IDLE with all outputs 0. With UNIQUE_DIGITS_EN, secret 16'h1123 -> err pulse, remains in P1_SECRET.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the two-player code-guessing game.
package game_pkg;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StP1Secret = 4'd1,
    StP2Secret = 4'd2,
    StP1Turn   = 4'd3,
    StP1Check  = 4'd4,
    StP2Turn   = 4'd5,
    StP2Check  = 4'd6,
    StP1Wins   = 4'd7,
    StP2Wins   = 4'd8,
    StDraw     = 4'd9
  } game_state_e;

  // Checker result layout: {wrong_place, right_place}
  localparam int unsigned RightLsb = 0;
  localparam int unsigned RightMsb = 3;
  localparam int unsigned WrongLsb = 4;
  localparam int unsigned WrongMsb = 7;

  localparam int unsigned DefaultDigits     = 4;
  localparam int unsigned DefaultMaxGuesses = 10;

endpackage

// File: rtl/game_turn_controller_cycle_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module cycle_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  output logic             expired
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/game_turn_controller.sv
// Turn sequencer for the code-guessing game. Define UNIQUE_DIGITS_EN to reject
// secrets containing repeated nibbles.
module game_turn_controller
  import game_pkg::*;
#(
  parameter int unsigned DIGITS          = DefaultDigits,
  parameter int unsigned MAX_GUESSES     = DefaultMaxGuesses,
  parameter int unsigned WIN_HOLD_CYCLES = 256,
  parameter int unsigned CHK_TIMEOUT     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_pulse,
  input  logic [4*DIGITS-1:0] sw_value,
  input  logic [7:0]          chk_result,
  input  logic                chk_valid,
  output logic                chk_start,
  output logic [4*DIGITS-1:0] chk_answer,
  output logic [4*DIGITS-1:0] chk_guess,
  output logic                active_player,
  output logic [3:0]          state_code,
  output logic [7:0]          last_result,
  output logic [3:0]          guess_cnt_p1,
  output logic [3:0]          guess_cnt_p2,
  output logic                win_p1,
  output logic                win_p2,
  output logic                draw,
  output logic                err
);

  localparam int unsigned CodeW = 4 * DIGITS;
  localparam int unsigned ToW   = $clog2(CHK_TIMEOUT + 1);
  localparam int unsigned HoldW = $clog2(WIN_HOLD_CYCLES + 1);

  game_state_e      state_q, state_d;
  logic [CodeW-1:0] secret_p1_q, secret_p1_d;
  logic [CodeW-1:0] secret_p2_q, secret_p2_d;
  logic [CodeW-1:0] guess_q, guess_d;
  logic [CodeW-1:0] answer_q, answer_d;
  logic [3:0]       cnt_p1_q, cnt_p1_d;
  logic [3:0]       cnt_p2_q, cnt_p2_d;
  logic [7:0]       result_q, result_d;
  logic             start_q, start_d;
  logic             err_q, err_d;
  logic             state_entry;
  logic             to_expired;
  logic             hold_expired;
  logic             secret_ok;
  logic             win_hit;
  logic [3:0]       cnt_p1_inc;
  logic [3:0]       cnt_p2_inc;

`ifdef UNIQUE_DIGITS_EN
  always_comb begin
    secret_ok = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      for (int j = i + 1; j < int'(DIGITS); j++) begin
        if (sw_value[4*i +: 4] == sw_value[4*j +: 4]) begin
          secret_ok = 1'b0;
        end
      end
    end
  end
`else
  assign secret_ok = 1'b1;
`endif

  assign win_hit    = (chk_result[RightMsb:RightLsb] == 4'(DIGITS));
  assign cnt_p1_inc = (cnt_p1_q < 4'(MAX_GUESSES)) ? cnt_p1_q + 4'd1 : cnt_p1_q;
  assign cnt_p2_inc = (cnt_p2_q < 4'(MAX_GUESSES)) ? cnt_p2_q + 4'd1 : cnt_p2_q;

  // Both timers restart on any state entry; each is only consulted in its own states.
  assign state_entry = (state_d != state_q);

  cycle_timer #(
    .Width(ToW)
  ) u_check_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (state_entry),
    .load_value(ToW'(CHK_TIMEOUT - 1)),
    .expired   (to_expired)
  );

  cycle_timer #(
    .Width(HoldW)
  ) u_hold_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (state_entry),
    .load_value(HoldW'(WIN_HOLD_CYCLES - 1)),
    .expired   (hold_expired)
  );

  always_comb begin
    state_d     = state_q;
    secret_p1_d = secret_p1_q;
    secret_p2_d = secret_p2_q;
    guess_d     = guess_q;
    answer_d    = answer_q;
    cnt_p1_d    = cnt_p1_q;
    cnt_p2_d    = cnt_p2_q;
    result_d    = result_q;
    start_d     = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      StIdle: begin
        if (btn_pulse) begin
          state_d  = StP1Secret;
          cnt_p1_d = '0;
          cnt_p2_d = '0;
          result_d = '0;
        end
      end
      StP1Secret: begin
        if (btn_pulse) begin
          if (secret_ok) begin
            secret_p1_d = sw_value;
            state_d     = StP2Secret;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StP2Secret: begin
        if (btn_pulse) begin
          if (secret_ok) begin
            secret_p2_d = sw_value;
            state_d     = StP1Turn;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StP1Turn: begin
        if (btn_pulse) begin
          guess_d  = sw_value;
          answer_d = secret_p2_q;
          start_d  = 1'b1;
          state_d  = StP1Check;
        end
      end
      StP1Check: begin
        // A result arriving on the expiry cycle takes priority over the timeout.
        if (chk_valid) begin
          result_d = chk_result;
          cnt_p1_d = cnt_p1_inc;
          state_d  = win_hit ? StP1Wins : StP2Turn;
        end else if (to_expired) begin
          err_d   = 1'b1;
          state_d = StP1Turn;
        end
      end
      StP2Turn: begin
        if (btn_pulse) begin
          guess_d  = sw_value;
          answer_d = secret_p1_q;
          start_d  = 1'b1;
          state_d  = StP2Check;
        end
      end
      StP2Check: begin
        if (chk_valid) begin
          result_d = chk_result;
          cnt_p2_d = cnt_p2_inc;
          if (win_hit) begin
            state_d = StP2Wins;
          end else if (cnt_p2_inc == 4'(MAX_GUESSES)) begin
            state_d = StDraw;
          end else begin
            state_d = StP1Turn;
          end
        end else if (to_expired) begin
          err_d   = 1'b1;
          state_d = StP2Turn;
        end
      end
      StP1Wins, StP2Wins, StDraw: begin
        if (hold_expired) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      secret_p1_q <= '0;
      secret_p2_q <= '0;
      guess_q     <= '0;
      answer_q    <= '0;
      cnt_p1_q    <= '0;
      cnt_p2_q    <= '0;
      result_q    <= '0;
      start_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      secret_p1_q <= secret_p1_d;
      secret_p2_q <= secret_p2_d;
      guess_q     <= guess_d;
      answer_q    <= answer_d;
      cnt_p1_q    <= cnt_p1_d;
      cnt_p2_q    <= cnt_p2_d;
      result_q    <= result_d;
      start_q     <= start_d;
      err_q       <= err_d;
    end
  end

  assign chk_start     = start_q;
  assign chk_answer    = answer_q;
  assign chk_guess     = guess_q;
  assign active_player = (state_q == StP2Secret) || (state_q == StP2Turn) ||
                         (state_q == StP2Check);
  assign state_code    = state_q;
  assign last_result   = result_q;
  assign guess_cnt_p1  = cnt_p1_q;
  assign guess_cnt_p2  = cnt_p2_q;
  assign win_p1        = (state_q == StP1Wins);
  assign win_p2        = (state_q == StP2Wins);
  assign draw          = (state_q == StDraw);
  assign err           = err_q;

endmodule
